// File: rtl/pong_pkg.sv
// Shared constants for the Pong game engine: FSM state codes, ball/paddle
// direction codes and the centring helper used for reset and serve positions.
package pong_pkg;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_SERVE     = 2'd1;
    localparam logic [1:0] ST_PLAY      = 2'd2;
    localparam logic [1:0] ST_GAME_OVER = 2'd3;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;
    localparam logic DIR_UP    = 1'b0;
    localparam logic DIR_DOWN  = 1'b1;

    function automatic int centre_coord(input int field, input int size);
        return (field - size) / 2;
    endfunction

endpackage

// File: rtl/pong_paddle.sv
// Vertical paddle: steps by STEP pixels per enabled frame and saturates at the
// top and bottom of the playfield.
module pong_paddle #(
    parameter int COORD_W  = 10,
    parameter int FIELD_H  = 480,
    parameter int PADDLE_H = 64,
    parameter int STEP     = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               up,
    input  logic               down,
    output logic [COORD_W-1:0] y
);
    localparam logic [COORD_W-1:0]        Y_RST  = COORD_W'((FIELD_H - PADDLE_H) / 2);
    localparam logic [COORD_W-1:0]        Y_MAX  = COORD_W'(FIELD_H - PADDLE_H);
    localparam logic signed [COORD_W:0]   Y_MAX_S = (COORD_W+1)'(FIELD_H - PADDLE_H);
    localparam logic signed [COORD_W:0]   STEP_S = (COORD_W+1)'(STEP);
    localparam logic signed [COORD_W:0]   ZERO_S = '0;

    logic [COORD_W-1:0]      y_q;
    logic [COORD_W-1:0]      y_d;
    logic signed [COORD_W:0] y_up_s;
    logic signed [COORD_W:0] y_dn_s;

    assign y_up_s = $signed({1'b0, y_q}) - STEP_S;
    assign y_dn_s = $signed({1'b0, y_q}) + STEP_S;

    // Next position with saturation; opposing buttons cancel.
    always_comb begin
        y_d = y_q;
        if (en && up && !down) begin
            if (y_up_s <= ZERO_S) begin
                y_d = '0;
            end else begin
                y_d = y_up_s[COORD_W-1:0];
            end
        end else if (en && down && !up) begin
            if (y_dn_s >= Y_MAX_S) begin
                y_d = Y_MAX;
            end else begin
                y_d = y_dn_s[COORD_W-1:0];
            end
        end else begin
            y_d = y_q;
        end
    end

    // Paddle position register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q <= Y_RST;
        end else begin
            y_q <= y_d;
        end
    end

    assign y = y_q;

endmodule

// File: rtl/pong_engine.sv
// Per-frame Pong game state: ball motion and bounces, player and AI paddles,
// scoring and the IDLE/SERVE/PLAY/GAME_OVER match sequence.
module pong_engine
    import pong_pkg::*;
#(
    parameter int COORD_W      = 10,
    parameter int FIELD_W      = 640,
    parameter int FIELD_H      = 480,
    parameter int PADDLE_X     = 16,
    parameter int PADDLE_W     = 8,
    parameter int PADDLE_H     = 64,
    parameter int BALL_SIZE    = 8,
    parameter int BALL_SPEED   = 2,
    parameter int PADDLE_SPEED = 4,
    parameter int AI_SPEED     = 3,
    parameter int SCORE_W      = 4,
    parameter int WIN_SCORE    = 9,
    parameter int SERVE_FRAMES = 60
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 frame_tick,
    input  logic                 btn_up,
    input  logic                 btn_down,
    input  logic                 start,
    output logic [COORD_W-1:0]   current_ball_x,
    output logic [COORD_W-1:0]   current_ball_y,
    output logic [COORD_W-1:0]   player_paddle_y,
    output logic [COORD_W-1:0]   opponent_paddle_y,
    output logic [2*SCORE_W-1:0] score,
    output logic                 game_over,
    output logic [1:0]           state
);
    localparam int CNT_W = $clog2(SERVE_FRAMES + 1);
    localparam logic [CNT_W-1:0]        CNT_LAST = CNT_W'(SERVE_FRAMES - 1);
    localparam logic [COORD_W-1:0]      BALL_X0  = COORD_W'(centre_coord(FIELD_W, BALL_SIZE));
    localparam logic [COORD_W-1:0]      BALL_Y0  = COORD_W'(centre_coord(FIELD_H, BALL_SIZE));
    localparam logic [SCORE_W-1:0]      WIN_S    = SCORE_W'(WIN_SCORE);
    localparam logic signed [COORD_W:0] SPD_S    = (COORD_W+1)'(BALL_SPEED);
    localparam logic signed [COORD_W:0] L_LIM_S  = (COORD_W+1)'(PADDLE_X + PADDLE_W);
    localparam logic signed [COORD_W:0] R_LIM_S  = (COORD_W+1)'(FIELD_W - PADDLE_X - PADDLE_W - BALL_SIZE);
    localparam logic signed [COORD_W:0] R_OUT_S  = (COORD_W+1)'(FIELD_W - BALL_SIZE - BALL_SPEED);
    localparam logic signed [COORD_W:0] Y_MAX_S  = (COORD_W+1)'(FIELD_H - BALL_SIZE);
    localparam logic signed [COORD_W:0] ZERO_S   = '0;
    localparam logic signed [COORD_W:0] BC_S     = (COORD_W+1)'(BALL_SIZE / 2);
    localparam logic signed [COORD_W:0] PC_S     = (COORD_W+1)'(PADDLE_H / 2);
    localparam logic signed [COORD_W:0] AI_S     = (COORD_W+1)'(AI_SPEED);
    localparam logic [COORD_W:0]        BS_U     = (COORD_W+1)'(BALL_SIZE);
    localparam logic [COORD_W:0]        PH_U     = (COORD_W+1)'(PADDLE_H);

    logic [1:0]          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [COORD_W-1:0]  ball_x_q, ball_x_d, ball_y_q, ball_y_d;
    logic                dir_x_q, dir_x_d, dir_y_q, dir_y_d;
    logic [SCORE_W-1:0]  score_p_q, score_p_d, score_o_q, score_o_d;
    logic                game_over_q, game_over_d;

    logic [COORD_W-1:0]      ply_s, opy_s;
    logic                    pad_en_s, ai_up_s, ai_dn_s, pl_ovl_s, op_ovl_s;
    logic                    pl_pt_s, op_pt_s;
    logic signed [COORD_W:0] bx_s, by_s, nx_s, ny_s, ball_c_s, pad_c_s;

    assign pad_en_s = frame_tick && ((state_q == ST_SERVE) || (state_q == ST_PLAY));

    // AI steers the opponent paddle centre toward the ball centre outside a deadband.
    assign ball_c_s = $signed({1'b0, ball_y_q}) + BC_S;
    assign pad_c_s  = $signed({1'b0, opy_s}) + PC_S;
    assign ai_dn_s  = ball_c_s > (pad_c_s + AI_S);
    assign ai_up_s  = ball_c_s < (pad_c_s - AI_S);

    pong_paddle #(.COORD_W(COORD_W), .FIELD_H(FIELD_H), .PADDLE_H(PADDLE_H), .STEP(PADDLE_SPEED))
        u_player (.clk(clk), .rst_n(rst_n), .en(pad_en_s), .up(btn_up), .down(btn_down), .y(ply_s));

    pong_paddle #(.COORD_W(COORD_W), .FIELD_H(FIELD_H), .PADDLE_H(PADDLE_H), .STEP(AI_SPEED))
        u_opponent (.clk(clk), .rst_n(rst_n), .en(pad_en_s), .up(ai_up_s), .down(ai_dn_s), .y(opy_s));

    assign pl_ovl_s = (({1'b0, ball_y_q} + BS_U) > {1'b0, ply_s}) && ({1'b0, ball_y_q} < ({1'b0, ply_s} + PH_U));
    assign op_ovl_s = (({1'b0, ball_y_q} + BS_U) > {1'b0, opy_s}) && ({1'b0, ball_y_q} < ({1'b0, opy_s} + PH_U));

    assign bx_s = $signed({1'b0, ball_x_q});
    assign by_s = $signed({1'b0, ball_y_q});
    assign nx_s = (dir_x_q == DIR_RIGHT) ? (bx_s + SPD_S) : (bx_s - SPD_S);
    assign ny_s = (dir_y_q == DIR_DOWN) ? (by_s + SPD_S) : (by_s - SPD_S);

    // Match FSM, ball motion and scoring; everything holds between frame ticks.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ball_x_d    = ball_x_q;
        ball_y_d    = ball_y_q;
        dir_x_d     = dir_x_q;
        dir_y_d     = dir_y_q;
        score_p_d   = score_p_q;
        score_o_d   = score_o_q;
        game_over_d = game_over_q;
        pl_pt_s     = 1'b0;
        op_pt_s     = 1'b0;
        if (frame_tick) begin
            case (state_q)
                ST_IDLE: begin
                    ball_x_d = BALL_X0;
                    ball_y_d = BALL_Y0;
                    if (start) begin
                        state_d   = ST_SERVE;
                        cnt_d     = '0;
                        score_p_d = '0;
                        score_o_d = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_SERVE: begin
                    ball_x_d = BALL_X0;
                    ball_y_d = BALL_Y0;
                    if (cnt_q == CNT_LAST) begin
                        state_d = ST_PLAY;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1'b1);
                    end
                end
                ST_PLAY: begin
                    if (dir_y_q == DIR_UP) begin
                        if (ny_s <= ZERO_S) begin
                            ball_y_d = '0;
                            dir_y_d  = DIR_DOWN;
                        end else begin
                            ball_y_d = ny_s[COORD_W-1:0];
                        end
                    end else begin
                        if (ny_s >= Y_MAX_S) begin
                            ball_y_d = Y_MAX_S[COORD_W-1:0];
                            dir_y_d  = DIR_UP;
                        end else begin
                            ball_y_d = ny_s[COORD_W-1:0];
                        end
                    end
                    // Paddle contact is judged against the paddles as they were before this frame.
                    if (dir_x_q == DIR_LEFT) begin
                        if ((nx_s <= L_LIM_S) && pl_ovl_s) begin
                            ball_x_d = L_LIM_S[COORD_W-1:0];
                            dir_x_d  = DIR_RIGHT;
                        end else if (bx_s < SPD_S) begin
                            op_pt_s = 1'b1;
                        end else begin
                            ball_x_d = nx_s[COORD_W-1:0];
                        end
                    end else begin
                        if ((nx_s >= R_LIM_S) && op_ovl_s) begin
                            ball_x_d = R_LIM_S[COORD_W-1:0];
                            dir_x_d  = DIR_LEFT;
                        end else if (bx_s > R_OUT_S) begin
                            pl_pt_s = 1'b1;
                        end else begin
                            ball_x_d = nx_s[COORD_W-1:0];
                        end
                    end
                    if (op_pt_s || pl_pt_s) begin
                        ball_x_d = BALL_X0;
                        ball_y_d = BALL_Y0;
                        cnt_d    = '0;
                        if (op_pt_s) begin
                            score_o_d = score_o_q + SCORE_W'(1'b1);
                            dir_x_d   = DIR_LEFT;
                        end else begin
                            score_p_d = score_p_q + SCORE_W'(1'b1);
                            dir_x_d   = DIR_RIGHT;
                        end
                        if ((score_o_d == WIN_S) || (score_p_d == WIN_S)) begin
                            state_d     = ST_GAME_OVER;
                            game_over_d = 1'b1;
                        end else begin
                            state_d = ST_SERVE;
                        end
                    end else begin
                        state_d = ST_PLAY;
                    end
                end
                ST_GAME_OVER: begin
                    if (start) begin
                        state_d     = ST_SERVE;
                        cnt_d       = '0;
                        score_p_d   = '0;
                        score_o_d   = '0;
                        dir_x_d     = DIR_RIGHT;
                        game_over_d = 1'b0;
                    end else begin
                        state_d = ST_GAME_OVER;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Game state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            ball_x_q    <= BALL_X0;
            ball_y_q    <= BALL_Y0;
            dir_x_q     <= DIR_RIGHT;
            dir_y_q     <= DIR_DOWN;
            score_p_q   <= '0;
            score_o_q   <= '0;
            game_over_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ball_x_q    <= ball_x_d;
            ball_y_q    <= ball_y_d;
            dir_x_q     <= dir_x_d;
            dir_y_q     <= dir_y_d;
            score_p_q   <= score_p_d;
            score_o_q   <= score_o_d;
            game_over_q <= game_over_d;
        end
    end

    assign current_ball_x    = ball_x_q;
    assign current_ball_y    = ball_y_q;
    assign player_paddle_y   = ply_s;
    assign opponent_paddle_y = opy_s;
    assign score             = {score_o_q, score_p_q};
    assign game_over         = game_over_q;
    assign state             = state_q;

endmodule

// File: doc/pong_engine.md
# pong_engine

Parametrised game-state engine for the Pong design. Owns ball position and direction, both paddle positions, the two scores and the match state machine, advancing once per video frame. Sits between the input synchroniser and the VGA renderer inside `tt_um_PongGame`. Generalises the fixed-geometry ball/paddle/score logic with configurable field, object sizes and speeds, a serve delay, an AI opponent and a win/game-over condition.

## Interface
Parameters:
- `COORD_W`, 10, width of every coordinate
- `FIELD_W` / `FIELD_H`, 640 / 480, playfield size in pixels
- `PADDLE_X`, 16, left edge of the player paddle; opponent left edge = `FIELD_W-PADDLE_X-PADDLE_W`
- `PADDLE_W` / `PADDLE_H`, 8 / 64, paddle size
- `BALL_SIZE`, 8, square ball side
- `BALL_SPEED`, 2, ball pixels per frame on each axis
- `PADDLE_SPEED` / `AI_SPEED`, 4 / 3, player / opponent pixels per frame
- `SCORE_W` / `WIN_SCORE`, 4 / 9, score width and winning score
- `SERVE_FRAMES`, 60, frames the ball is held before a serve

Ports:
- `clk` in 1: system clock
- `rst_n` in 1: asynchronous, active-low reset
- `frame_tick` in 1: one-cycle pulse per frame (start of vblank)
- `btn_up`, `btn_down` in 1 each: synchronised player controls
- `start` in 1: level; sampled on `frame_tick`
- `current_ball_x`, `current_ball_y` out `COORD_W`: ball top-left corner
- `player_paddle_y`, `opponent_paddle_y` out `COORD_W`: paddle top edges
- `score` out `2*SCORE_W`: {opponent, player}
- `game_over` out 1: high in GAME_OVER
- `state` out 2: current FSM state (debug)

## Operation
- States: IDLE=0, SERVE=1, PLAY=2, GAME_OVER=3. Reset -> IDLE.
- All state updates occur only on a cycle with `frame_tick`=1. Other cycles hold every register.
- IDLE: ball centred at ((FIELD_W-BALL_SIZE)/2, (FIELD_H-BALL_SIZE)/2) = (316,236). Paddles frozen. `start` -> SERVE with scores cleared.
- SERVE: ball held at centre. Serve counter counts ticks; after `SERVE_FRAMES` ticks in SERVE -> PLAY. Paddles move.
- PLAY:
  - Player paddle: moves up by `PADDLE_SPEED` if `btn_up`&!`btn_down`, down if the reverse, otherwise holds. Clamped to [0, FIELD_H-PADDLE_H].
  - Opponent AI: compares paddle centre with ball centre. Deadband ±`AI_SPEED`. Steps `AI_SPEED` toward the ball, with the same clamp.
  - Vertical: next_y = y ± BALL_SPEED. If next_y ≤ 0, y=0 and direction becomes down. If next_y ≥ FIELD_H-BALL_SIZE, clamp and direction becomes up.
  - Horizontal, moving left: if next_x ≤ PADDLE_X+PADDLE_W and the ball overlaps the paddle vertically (ball_y+BALL_SIZE > pad_y and ball_y < pad_y+PADDLE_H), then x = PADDLE_X+PADDLE_W and direction becomes right. Else, if x < BALL_SPEED, the opponent scores.
  - Horizontal, moving right: mirror of the left case, using the opponent paddle and FIELD_W-BALL_SIZE.
  - Collision checks use pre-update paddle positions. Axes are evaluated independently, so a corner hit flips both directions in the same tick.
- Score event: the scorer's count increments. If it now equals `WIN_SCORE` -> GAME_OVER, else -> SERVE. In both cases the ball re-centres.
  - Serve direction is toward the player who conceded; vertical direction is preserved.
- GAME_OVER: everything frozen. `start` -> SERVE with scores cleared and serve direction right.
- Arithmetic: all next-position calculations in `COORD_W+1`-bit signed, so underflow/overflow is detected before clamping. Scores never exceed `WIN_SCORE`.
- Initial direction after reset: right, down.

## Timing
- Reset values:
  - `current_ball_x`=316, `current_ball_y`=236
  - both paddles = (FIELD_H-PADDLE_H)/2 = 208
  - `score`=0, `game_over`=0, `state`=IDLE
  - serve counter = 0
- Latency: outputs reflect the tick's inputs on the clock edge that samples `frame_tick`=1, i.e. 1 cycle after the tick is asserted. All outputs come directly from registers.
- `rst_n` low mid-frame or mid-play restores reset values asynchronously. The first tick after release is processed normally.
- `frame_tick` held high for N cycles counts as N frames. The driver must guarantee single-cycle pulses.

## Structure
- `pong_pkg`: state enum, direction constants (DIR_LEFT/RIGHT/UP/DOWN), and a function computing the centre coordinates from the parameters.
- Sub-module `pong_paddle` (params COORD_W, FIELD_H, PADDLE_H, STEP; ports clk, rst_n, en, up, down, y). Instantiated twice: the player instance is driven by the buttons, the AI instance by a comparator in `pong_engine`.
- Ball, FSM and score logic stay in `pong_engine`.

## Test plan
- Reset, then no `start` for 10 ticks -> outputs remain 316/236/208/208, score 0, state IDLE.
- `start`, then count ticks -> state becomes PLAY exactly on the 60th tick in SERVE. On the next tick ball = (318,238).
- Player paddle at 0 with `btn_up` held for 5 ticks -> stays 0. With `btn_down` held for 200 ticks -> saturates at 416.
- Ball forced toward the top wall at y=1 moving up -> next tick y=0 and direction down. The following tick y=2.
- Ball moving left, player paddle at 208, ball_y=230 reaching x≤24 -> x=24, direction right, no score change. Move the paddle to 0 instead -> score becomes 0x10, state SERVE, ball re-centred, serve direction left.
- Opponent reaches 9 points -> `game_over`=1 and all outputs frozen for 20 ticks. Then `start` -> score 0, SERVE. Assert `rst_n`=0 mid-PLAY -> reset values appear immediately, without a clock edge.
